// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with per-slot input capture,
// leading-zero blanking, blink, decimal points and PWM brightness.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_CNT = 100_000,
  parameter int BLINK_CNT   = 50_000_000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic [NUM_DIGITS-1:0]   blank_en,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [0:6]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    scan_tick
);

  localparam int   TW  = $clog2(REFRESH_CNT);
  localparam int   IW  = $clog2(NUM_DIGITS);
  localparam int   BW  = $clog2(BLINK_CNT);
  localparam logic INV = (ACTIVE_LOW == 0);

  logic [TW-1:0]           r_timer;
  logic [IW-1:0]           r_index;
  logic                    r_first;
  logic                    r_tick;
  logic [BW-1:0]           r_bcnt;
  logic                    r_blink;

  logic [4*NUM_DIGITS-1:0] r_s_digits;
  logic [NUM_DIGITS-1:0]   r_s_dp;
  logic [NUM_DIGITS-1:0]   r_s_blank;
  logic [NUM_DIGITS-1:0]   r_s_blinken;
  logic                    r_s_lz;
  logic [3:0]              r_s_bright;

  logic [0:6]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_slot_end;
  logic                    w_idx_last;
  logic                    w_load;
  logic [3:0]              w_cur;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_dark;
  logic [39:0]             w_prod;
  logic                    w_on;
  logic [6:0]              w_seg_al;
  logic                    w_dp_al;
  logic [NUM_DIGITS-1:0]   w_an_al;

  function automatic logic [6:0] f_code(input logic [3:0] v);
    case (v)
      4'd0:    f_code = 7'b1000000;
      4'd1:    f_code = 7'b1111001;
      4'd2:    f_code = 7'b0100100;
      4'd3:    f_code = 7'b0110000;
      4'd4:    f_code = 7'b0011001;
      4'd5:    f_code = 7'b0010010;
      4'd6:    f_code = 7'b0000010;
      4'd7:    f_code = 7'b1111000;
      4'd8:    f_code = 7'b0000000;
      4'd9:    f_code = 7'b0010000;
      default: f_code = 7'b1111110;
    endcase
  endfunction

  assign w_slot_end = (r_timer == TW'(REFRESH_CNT - 1));
  assign w_idx_last = (r_index == IW'(NUM_DIGITS - 1));
  assign w_load     = r_first | w_slot_end;

  // The first clock after reset only captures; the timer holds at 0
  // so slot 0 still gets a full REFRESH_CNT clocks of display.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
      r_index <= '0;
      r_first <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_first <= 1'b0;
      r_tick  <= w_slot_end & w_idx_last & ~r_first;
      if (!r_first) begin
        if (w_slot_end) begin
          r_timer <= '0;
          r_index <= w_idx_last ? '0 : r_index + IW'(1);
        end else begin
          r_timer <= r_timer + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_bcnt  <= '0;
      r_blink <= 1'b0;
    end else if (r_bcnt == BW'(BLINK_CNT - 1)) begin
      r_bcnt  <= '0;
      r_blink <= ~r_blink;
    end else begin
      r_bcnt  <= r_bcnt + BW'(1);
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_s_digits  <= '0;
      r_s_dp      <= '0;
      r_s_blank   <= '0;
      r_s_blinken <= '0;
      r_s_lz      <= 1'b0;
      r_s_bright  <= '0;
    end else if (w_load) begin
      r_s_digits  <= digits_bcd;
      r_s_dp      <= dp_en;
      r_s_blank   <= blank_en;
      r_s_blinken <= blink_en;
      r_s_lz      <= lz_suppress;
      r_s_bright  <= brightness;
    end
  end

  always_comb begin : p_lz
    logic v_nz;
    v_nz = 1'b0;
    w_lz = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_lz[i] = r_s_lz & ~v_nz & (r_s_digits[4*i +: 4] == 4'd0);
      v_nz    = v_nz | (r_s_digits[4*i +: 4] != 4'd0);
    end
  end

  assign w_cur  = r_s_digits[4*int'(r_index) +: 4];
  assign w_dark = r_s_blank[r_index]
                | (r_s_blinken[r_index] & r_blink)
                | w_lz[r_index];

  // 40-bit product keeps (brightness+1)*REFRESH_CNT exact.
  assign w_prod = (40'(r_s_bright) + 40'd1) * 40'(REFRESH_CNT);
  assign w_on   = 40'(r_timer) < (w_prod >> 4);

  assign w_seg_al = w_dark ? 7'b1111111 : f_code(w_cur);
  assign w_dp_al  = ~(r_s_dp[r_index] & ~w_dark);

  always_comb begin
    w_an_al = '1;
    if (w_on) w_an_al[r_index] = 1'b0;
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_seg <= {7{~INV}};
      r_dp  <= ~INV;
      r_an  <= {NUM_DIGITS{~INV}};
    end else if (r_first) begin
      r_seg <= {7{~INV}};
      r_dp  <= ~INV;
      r_an  <= {NUM_DIGITS{~INV}};
    end else begin
      r_seg <= w_seg_al ^ {7{INV}};
      r_dp  <= w_dp_al ^ INV;
      r_an  <= w_an_al ^ {NUM_DIGITS{INV}};
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign an        = r_an;
  assign scan_tick = r_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed table-driven bench for seg7_scan_driver
// (4 digits, 16-clock slots, 64-clock blink, active-low).
module tb_seg7_scan_driver;

  logic        clk_100MHz = 1'b0;
  logic        reset      = 1'b1;
  logic [15:0] digits_bcd = '0;
  logic [3:0]  dp_en      = '0;
  logic [3:0]  blank_en   = '0;
  logic [3:0]  blink_en   = '0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        scan_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_s = -2;

  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C4 = 7'b0011001;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] DK = 7'b1111111;
  localparam logic [6:0] DS = 7'b1111110;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_CNT(16),
    .BLINK_CNT  (64),
    .ACTIVE_LOW (1)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .digits_bcd (digits_bcd),
    .dp_en      (dp_en),
    .blank_en   (blank_en),
    .blink_en   (blink_en),
    .lz_suppress(lz_suppress),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .scan_tick  (scan_tick)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    string       nm;
    logic [15:0] d;
    logic [3:0]  dpe;
    logic [3:0]  blk;
    logic [3:0]  bln;
    logic        lz;
    logic [3:0]  br;
    int          s;
    logic [6:0]  eseg;
    logic        edp;
    logic [3:0]  ean;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic [15:0] d, logic [3:0] dpe,
                              logic [3:0] blk, logic [3:0] bln, logic lz,
                              logic [3:0] br, int s, logic [6:0] eseg,
                              logic edp, logic [3:0] ean);
    vec_t v;
    v.nm = nm; v.d = d; v.dpe = dpe; v.blk = blk; v.bln = bln;
    v.lz = lz; v.br = br; v.s = s;
    v.eseg = eseg; v.edp = edp; v.ean = ean;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic [6:0] es, logic ed, logic [3:0] ea);
    chk({nm, ".seg"}, 32'(seg), 32'(es));
    chk({nm, ".dp"},  32'(dp),  32'(ed));
    chk({nm, ".an"},  32'(an),  32'(ea));
  endtask

  // Slot clock s is the s-th displayed clock after release; its
  // output settles after edge s+2 counted from release.
  task automatic go(int s);
    repeat (s - cur_s) @(posedge clk_100MHz);
    #1;
    cur_s = s;
  endtask

  task automatic restart(logic [15:0] d, logic [3:0] dpe, logic [3:0] blk,
                         logic [3:0] bln, logic lz, logic [3:0] br);
    reset = 1'b1;
    digits_bcd = d; dp_en = dpe; blank_en = blk; blink_en = bln;
    lz_suppress = lz; brightness = br;
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    cur_s = -2;
  endtask

  initial begin
    tbl.push_back(mk("d0",      16'h1234, 4'h0, 4'h0, 4'h0, 0, 15,   0, C4, 1, 4'b1110));
    tbl.push_back(mk("d1",      16'h1234, 4'h0, 4'h0, 4'h0, 0, 15,  16, C3, 1, 4'b1101));
    tbl.push_back(mk("d2",      16'h1234, 4'h0, 4'h0, 4'h0, 0, 15,  32, C2, 1, 4'b1011));
    tbl.push_back(mk("d3",      16'h1234, 4'h0, 4'h0, 4'h0, 0, 15,  48, C1, 1, 4'b0111));
    tbl.push_back(mk("d0end",   16'h1234, 4'h0, 4'h0, 4'h0, 0, 15,  15, C4, 1, 4'b1110));
    tbl.push_back(mk("wrap",    16'h1234, 4'h0, 4'h0, 4'h0, 0, 15,  69, C4, 1, 4'b1110));
    tbl.push_back(mk("lz_d3",   16'h0050, 4'h0, 4'h0, 4'h0, 1, 15,  48, DK, 1, 4'b0111));
    tbl.push_back(mk("lz_d2",   16'h0050, 4'h0, 4'h0, 4'h0, 1, 15,  32, DK, 1, 4'b1011));
    tbl.push_back(mk("lz_d1",   16'h0050, 4'h0, 4'h0, 4'h0, 1, 15,  16, C5, 1, 4'b1101));
    tbl.push_back(mk("lz_d0",   16'h0050, 4'h0, 4'h0, 4'h0, 1, 15,   0, C0, 1, 4'b1110));
    tbl.push_back(mk("nolz_d3", 16'h0050, 4'h0, 4'h0, 4'h0, 0, 15,  48, C0, 1, 4'b0111));
    tbl.push_back(mk("nolz_d2", 16'h0050, 4'h0, 4'h0, 4'h0, 0, 15,  32, C0, 1, 4'b1011));
    tbl.push_back(mk("z_d0",    16'h0000, 4'h0, 4'h0, 4'h0, 1, 15,   0, C0, 1, 4'b1110));
    tbl.push_back(mk("z_d1",    16'h0000, 4'h0, 4'h0, 4'h0, 1, 15,  16, DK, 1, 4'b1101));
    tbl.push_back(mk("br3_on",  16'h1234, 4'h0, 4'h0, 4'h0, 0,  3,   3, C4, 1, 4'b1110));
    tbl.push_back(mk("br3_off", 16'h1234, 4'h0, 4'h0, 4'h0, 0,  3,   4, C4, 1, 4'b1111));
    tbl.push_back(mk("br3_d1",  16'h1234, 4'h0, 4'h0, 4'h0, 0,  3,  20, C3, 1, 4'b1111));
    tbl.push_back(mk("br0_on",  16'h1234, 4'h0, 4'h0, 4'h0, 0,  0,   0, C4, 1, 4'b1110));
    tbl.push_back(mk("br0_off", 16'h1234, 4'h0, 4'h0, 4'h0, 0,  0,   1, C4, 1, 4'b1111));
    tbl.push_back(mk("blank1",  16'h1234, 4'h2, 4'h2, 4'h0, 0, 15,  16, DK, 1, 4'b1101));
    tbl.push_back(mk("dp_d2",   16'h1234, 4'h4, 4'h0, 4'h0, 0, 15,  32, C2, 0, 4'b1011));
    tbl.push_back(mk("dp_d3",   16'h1234, 4'h4, 4'h0, 4'h0, 0, 15,  48, C1, 1, 4'b0111));
    tbl.push_back(mk("dash",    16'hABCD, 4'h0, 4'h0, 4'h0, 0, 15,   0, DS, 1, 4'b1110));
    tbl.push_back(mk("bl_on",   16'h1234, 4'h0, 4'h0, 4'h1, 0, 15,   0, C4, 1, 4'b1110));
    tbl.push_back(mk("bl_off",  16'h1234, 4'h0, 4'h0, 4'h1, 0, 15,  64, DK, 1, 4'b1110));
    tbl.push_back(mk("bl_off2", 16'h1234, 4'h0, 4'h0, 4'h1, 0, 15,  79, DK, 1, 4'b1110));
    tbl.push_back(mk("bl_d1",   16'h1234, 4'h0, 4'h0, 4'h1, 0, 15,  80, C3, 1, 4'b1101));
    tbl.push_back(mk("bl_on2",  16'h1234, 4'h0, 4'h0, 4'h1, 0, 15, 128, C4, 1, 4'b1110));

    // Reset state
    repeat (3) @(negedge clk_100MHz);
    chk_out("rst", DK, 1'b1, 4'b1111);
    chk("rst.tick", 32'(scan_tick), 32'd0);

    foreach (tbl[k]) begin
      restart(tbl[k].d, tbl[k].dpe, tbl[k].blk, tbl[k].bln, tbl[k].lz, tbl[k].br);
      go(tbl[k].s);
      chk_out(tbl[k].nm, tbl[k].eseg, tbl[k].edp, tbl[k].ean);
    end

    // scan_tick: one pulse per 64 clocks, first at the digit-3 -> 0 wrap
    begin
      int cnt;
      int first;
      int last;
      int gap_bad;
      cnt = 0; first = -100; last = -100; gap_bad = 0;
      restart(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
      for (int s = -1; s < 256; s++) begin
        go(s);
        if (scan_tick === 1'b1) begin
          if (cnt == 0) first = s;
          else if (s - last != 64) gap_bad++;
          last = s;
          cnt++;
        end
      end
      chk("tick.count", 32'(cnt), 32'd4);
      chk("tick.first", 32'(first), 32'd63);
      chk("tick.gap", 32'(gap_bad), 32'd0);
    end

    // Mid-slot input change is held off until the next slot
    restart(16'h1234, 4'b0100, 4'h0, 4'h0, 1'b0, 4'd15);
    go(5);
    digits_bcd = 16'hABCD;
    go(10);
    chk_out("mid_hold", C4, 1'b1, 4'b1110);
    go(16);
    chk_out("mid_d1", DS, 1'b1, 4'b1101);
    go(32);
    chk_out("mid_d2", DS, 1'b0, 4'b1011);
    go(48);
    chk_out("mid_d3", DS, 1'b1, 4'b0111);

    // Asynchronous reset at index 2, timer 7
    restart(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
    go(38);
    chk_out("ar_pre", C2, 1'b1, 4'b1011);
    #2 reset = 1'b1;
    #1;
    chk_out("ar_now", DK, 1'b1, 4'b1111);
    chk("ar_tick", 32'(scan_tick), 32'd0);
    @(negedge clk_100MHz);
    reset = 1'b0;
    cur_s = -2;
    go(0);
    chk_out("ar_d0", C4, 1'b1, 4'b1110);
    go(15);
    chk_out("ar_d0e", C4, 1'b1, 4'b1110);
    go(16);
    chk_out("ar_d1", C3, 1'b1, 4'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
